ic_univ_cnt_reg: RTL and testbench

Parametrised universal counter/shift register with an output storage register, successor to the discrete 74-series counter and shift-register models. Combines modulo-N up/down counting, parallel load and serial shift in one synchronous core. Adds a 74590-style snapshot register that drives the bus output. Intended for the CPLD glue logic, as a cascadable divider, address counter or serial/parallel converter.

---
 rtl/ic_univ_cnt_reg_if.sv | 29 ++
 rtl/ic_univ_cnt_reg.sv | 73 +++++++
 tb/tb_ic_univ_cnt_reg.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ic_univ_cnt_reg_if.sv
// Control/data bundle for ic_univ_cnt_reg: mode, enables, load/serial data in;
// core, storage and carry/borrow status out.
interface ic_univ_cnt_reg_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       MODE;
    logic             CE;
    logic             UP;
    logic [WIDTH-1:0] D;
    logic             DI;
    logic             STB;
    logic             OEn;
    logic [WIDTH-1:0] QC;
    logic [WIDTH-1:0] Q;
    logic             SO;
    logic             CRn;
    logic             BRn;

    // Inputs are sampled on the rising clock edge; CRn/BRn are combinational.
    modport master (
        output MODE, CE, UP, D, DI, STB, OEn,
        input  QC, Q, SO, CRn, BRn
    );

    modport slave (
        input  MODE, CE, UP, D, DI, STB, OEn,
        output QC, Q, SO, CRn, BRn
    );
endinterface

// File: rtl/ic_univ_cnt_reg.sv
// Universal modulo-N up/down counter / shift register with a snapshot storage register.
// Define CNT_TRISTATE_EN to make Q tristate under control of OEn.
module ic_univ_cnt_reg #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic              C,
    input  logic              R,
    ic_univ_cnt_reg_if.slave  bus
);
    localparam logic [WIDTH-1:0] LP_TOP = WIDTH'(MODULUS - 1);

    localparam logic [1:0] LP_HOLD  = 2'b00;
    localparam logic [1:0] LP_COUNT = 2'b01;
    localparam logic [1:0] LP_SHIFT = 2'b10;
    localparam logic [1:0] LP_LOAD  = 2'b11;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_oreg;
    logic [WIDTH-1:0] w_next;
    logic             w_count_up;
    logic             w_count_dn;

    assign w_count_up = (bus.MODE == LP_COUNT) && bus.CE && bus.UP;
    assign w_count_dn = (bus.MODE == LP_COUNT) && bus.CE && !bus.UP;

    // Out-of-range values wrap to 0 going up but walk down normally.
    always_comb begin
        w_next = r_cnt;
        case (bus.MODE)
            LP_HOLD:  w_next = r_cnt;
            LP_COUNT: begin
                if (w_count_up) begin
                    if (r_cnt >= LP_TOP) w_next = '0;
                    else                 w_next = r_cnt + 1'b1;
                end else if (w_count_dn) begin
                    if (r_cnt == '0) w_next = LP_TOP;
                    else             w_next = r_cnt - 1'b1;
                end
            end
            LP_SHIFT: begin
                if (bus.CE) w_next = {r_cnt[WIDTH-2:0], bus.DI};
            end
            LP_LOAD:  w_next = bus.D;
            default:  w_next = r_cnt;
        endcase
    end

    // Storage captures the pre-edge core value, so it lags the core by one edge.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            r_cnt  <= '0;
            r_oreg <= '0;
        end else begin
            r_cnt <= w_next;
            if (bus.STB) r_oreg <= r_cnt;
        end
    end

    assign bus.QC  = r_cnt;
    assign bus.SO  = r_cnt[WIDTH-1];
    assign bus.CRn = ~(w_count_up && (r_cnt >= LP_TOP));
    assign bus.BRn = ~(w_count_dn && (r_cnt == '0));

`ifdef CNT_TRISTATE_EN
    assign bus.Q = bus.OEn ? {WIDTH{1'bz}} : r_oreg;
`else
    logic w_unused_oen;
    assign w_unused_oen = bus.OEn;
    assign bus.Q = r_oreg;
`endif

endmodule

// File: tb/tb_ic_univ_cnt_reg.sv
// Directed bench for ic_univ_cnt_reg at WIDTH=4, MODULUS=10: vector table plus
// hand-written reset, storage and output-enable sequences.
module tb_ic_univ_cnt_reg;
    localparam int W = 4;

    logic C = 1'b0;
    logic R = 1'b0;
    int   total = 0;
    int   bad   = 0;

    ic_univ_cnt_reg_if #(.WIDTH(W)) bus ();

    ic_univ_cnt_reg #(.WIDTH(W), .MODULUS(10)) dut (
        .C   (C),
        .R   (R),
        .bus (bus)
    );

    always #5 C = ~C;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0]   mode;
        logic         ce;
        logic         up;
        logic [W-1:0] d;
        logic         di;
        logic         stb;
        logic         exp_crn;   // before the edge
        logic         exp_brn;   // before the edge
        logic [W-1:0] exp_qc;    // after the edge
        logic [W-1:0] exp_q;     // after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] mode, input logic ce, input logic up,
                         input logic [W-1:0] d, input logic di, input logic stb);
        bus.MODE = mode;
        bus.CE   = ce;
        bus.UP   = up;
        bus.D    = d;
        bus.DI   = di;
        bus.STB  = stb;
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [W-1:0] eqc;
        @(negedge C);
        drive(v.mode, v.ce, v.up, v.d, v.di, v.stb);
        #1;
        chk($sformatf("v%0d_crn", idx), 32'(bus.CRn), 32'(v.exp_crn));
        chk($sformatf("v%0d_brn", idx), 32'(bus.BRn), 32'(v.exp_brn));
        @(posedge C);
        #1;
        eqc = v.exp_qc;
        chk($sformatf("v%0d_qc", idx), 32'(bus.QC), 32'(v.exp_qc));
        chk($sformatf("v%0d_q", idx), 32'(bus.Q), 32'(v.exp_q));
        chk($sformatf("v%0d_so", idx), 32'(bus.SO), 32'(eqc[W-1]));
    endtask

    function automatic vec_t mk(input logic [1:0] mode, input logic ce, input logic up,
                                input logic [W-1:0] d, input logic di, input logic stb,
                                input logic crn, input logic brn,
                                input logic [W-1:0] qc, input logic [W-1:0] q);
        vec_t v;
        v.mode = mode; v.ce = ce; v.up = up; v.d = d; v.di = di; v.stb = stb;
        v.exp_crn = crn; v.exp_brn = brn; v.exp_qc = qc; v.exp_q = q;
        return v;
    endfunction

    initial begin
        //             mode  ce    up    d    di    stb   crn   brn   qc   q
        // up wrap / carry
        vecs.push_back(mk(2'b11, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 4'd0));
        vecs.push_back(mk(2'b01, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 4'd0));
        vecs.push_back(mk(2'b01, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0));
        // same with CE=0 at 9
        vecs.push_back(mk(2'b11, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 4'd0));
        vecs.push_back(mk(2'b01, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 4'd0));
        vecs.push_back(mk(2'b01, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 4'd0));
        // load ignores CE=0
        vecs.push_back(mk(2'b11, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0));
        // down wrap / borrow
        vecs.push_back(mk(2'b01, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0));
        vecs.push_back(mk(2'b01, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd0));
        // out-of-range up and down
        vecs.push_back(mk(2'b11, 1'b1, 1'b0, 4'd13, 1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 4'd0));
        vecs.push_back(mk(2'b01, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0));
        vecs.push_back(mk(2'b11, 1'b1, 1'b0, 4'd13, 1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 4'd0));
        vecs.push_back(mk(2'b01, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 4'd0));
        // shift 1010 with DI = 1,1,0
        vecs.push_back(mk(2'b11, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 4'd0));
        vecs.push_back(mk(2'b10, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0101, 4'd0));
        vecs.push_back(mk(2'b10, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1011, 4'd0));
        vecs.push_back(mk(2'b10, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 4'd0));
        vecs.push_back(mk(2'b10, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110, 4'd0));
        vecs.push_back(mk(2'b00, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110, 4'd0));
        // storage snapshot on 5->6
        vecs.push_back(mk(2'b11, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 4'd0));
        vecs.push_back(mk(2'b01, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 4'd0));
        vecs.push_back(mk(2'b01, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd6, 4'd5));
        vecs.push_back(mk(2'b01, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 4'd5));
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd7));
        vecs.push_back(mk(2'b11, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 4'd7));
        vecs.push_back(mk(2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 4'd7));

        // reset state; borrow follows its equation with cnt = 0 while R is low
        drive(2'b01, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        bus.OEn = 1'b0;
        repeat (2) @(posedge C);
        #1;
        chk("rst_qc", 32'(bus.QC), 32'd0);
        chk("rst_q", 32'(bus.Q), 32'd0);
        chk("rst_so", 32'(bus.SO), 32'd0);
        chk("rst_brn", 32'(bus.BRn), 32'd0);
        chk("rst_crn", 32'(bus.CRn), 32'd1);
        @(negedge C);
        drive(2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        R = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // mid-count async reset: reach 7 with Q=6, then drop R between edges
        apply(mk(2'b11, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 4'd7), 100);
        apply(mk(2'b01, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd6), 101);
        @(posedge C);
        #2;
        R = 1'b0;
        #1;
        chk("arst_qc", 32'(bus.QC), 32'd0);
        chk("arst_q", 32'(bus.Q), 32'd0);
        // synchronous inputs ignored while R low
        drive(2'b11, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
        repeat (2) @(posedge C);
        #1;
        chk("arst_hold_qc", 32'(bus.QC), 32'd0);
        chk("arst_hold_q", 32'(bus.Q), 32'd0);
        @(negedge C);
        drive(2'b01, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        R = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge C);
            #1;
            chk($sformatf("resume_qc%0d", k), 32'(bus.QC), 32'(k));
        end

        // output enable: counter keeps running; Q depends on build
        @(negedge C);
        drive(2'b01, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        @(posedge C);
        #1;
        chk("oe_q_snap", 32'(bus.Q), 32'd3);
        @(negedge C);
        bus.STB = 1'b0;
        bus.OEn = 1'b1;
        @(posedge C);
        #1;
        chk("oe_qc", 32'(bus.QC), 32'd5);
`ifdef CNT_TRISTATE_EN
        chk("oe_q_z", 32'(bus.Q), 32'(4'bzzzz));
`else
        chk("oe_q_driven", 32'(bus.Q), 32'd3);
`endif
        @(negedge C);
        bus.OEn = 1'b0;
        #1;
        chk("oe_q_on", 32'(bus.Q), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
